// File: rtl/decode38_ctrl.sv
// Registered 3-to-8 decoder: latches a handshaked code and drives it one-hot for
// HOLD_CYCLES cycles, or chases the one-hot bit 0..7. Define DECODE38_ACTIVE_LOW_EN for one-cold output.
module decode38_ctrl #(
    parameter int HOLD_CYCLES = 16,
    parameter int SCAN_DIV    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_valid,
    input  logic [2:0] i_code,
    input  logic       i_scan,
    output logic       o_ready,
    output logic [7:0] o_onehot,
    output logic [2:0] o_code,
    output logic       o_active
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

`ifdef DECODE38_ACTIVE_LOW_EN
    localparam logic [7:0] OH_POLARITY = 8'hFF;
`else
    localparam logic [7:0] OH_POLARITY = 8'h00;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SCAN
    } state_t;

    state_t        state_reg, state_next;
    logic [2:0]    code_reg, code_next;
    logic [7:0]    onehot_reg, onehot_next;
    logic          active_reg, active_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [SW-1:0] div_reg, div_next;
    logic          transfer;

    assign o_ready  = i_en && (state_reg == ST_IDLE || state_reg == ST_SCAN);
    assign transfer = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            code_reg     <= 3'd0;
            onehot_reg   <= OH_POLARITY;
            active_reg   <= 1'b0;
            hold_cnt_reg <= '0;
            div_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            code_reg     <= code_next;
            onehot_reg   <= onehot_next;
            active_reg   <= active_next;
            hold_cnt_reg <= hold_cnt_next;
            div_reg      <= div_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        code_next     = code_reg;
        hold_cnt_next = hold_cnt_reg;
        div_next      = div_reg;

        if (!i_en) begin
            // Disable abandons any hold or scan in progress.
            state_next    = ST_IDLE;
            code_next     = 3'd0;
            hold_cnt_next = '0;
            div_next      = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (transfer) begin
                        state_next    = ST_HOLD;
                        code_next     = i_code;
                        hold_cnt_next = HW'(HOLD_CYCLES - 1);
                    end else if (i_scan) begin
                        state_next = ST_SCAN;
                        code_next  = 3'd0;
                        div_next   = '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_reg == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        hold_cnt_next = hold_cnt_reg - 1'b1;
                    end
                end
                ST_SCAN: begin
                    // A new code preempts the chaser.
                    if (transfer) begin
                        state_next    = ST_HOLD;
                        code_next     = i_code;
                        hold_cnt_next = HW'(HOLD_CYCLES - 1);
                    end else if (!i_scan) begin
                        state_next = ST_IDLE;
                    end else if (div_reg == SW'(SCAN_DIV - 1)) begin
                        div_next  = '0;
                        code_next = code_reg + 3'd1;
                    end else begin
                        div_next = div_reg + 1'b1;
                    end
                end
                default: begin
                    state_next    = ST_IDLE;
                    code_next     = 3'd0;
                    hold_cnt_next = '0;
                    div_next      = '0;
                end
            endcase
        end

        active_next = (state_next != ST_IDLE);
        onehot_next = active_next ? ((8'd1 << code_next) ^ OH_POLARITY) : OH_POLARITY;
    end

    assign o_onehot = onehot_reg;
    assign o_code   = code_reg;
    assign o_active = active_reg;

endmodule

// File: doc/decode38_ctrl.md
Name: decode38_ctrl

Overview:
Registered 3-to-8 decoder controller: the inverse of the team's 8-3 priority encoder.
- Accepts a 3-bit code through a valid/ready handshake and drives a one-hot 8-bit output for a programmable hold time.
- Alternatively runs a free scan, a chaser that walks the one-hot bit 0..7.
- Sits between the code source (encoder, switches, CPU register) and LED/segment-select drivers.

Parameters:
HOLD_CYCLES, 16, cycles the one-hot output stays asserted after a handshake accept; legal range >=1.
SCAN_DIV, 4, cycles per scan step in SCAN state; legal range >=1.

Ports:
i_clk  input  1  system clock, rising-edge.
i_rst_n  input  1  asynchronous active-low reset.
i_en  input  1  block enable; low forces IDLE on the next edge.
i_valid  input  1  code-valid strobe from the source.
i_code  input  3  code to decode.
i_scan  input  1  scan-mode request.
o_ready  output  1  block can accept i_code this cycle.
o_onehot  output  8  decoded one-hot output, registered.
o_code  output  3  currently latched or scanned code, registered.
o_active  output  1  high while in HOLD or SCAN.

Behaviour:
- One clock domain: i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: state=IDLE, o_onehot=8'h00, o_code=3'd0, o_active=0, hold counter=0, scan divider=0. o_ready is combinational from state, so it is 1 in reset/IDLE whenever i_en=1.
- o_ready = i_en && (state==IDLE || state==SCAN). A transfer occurs on an edge where i_valid && o_ready.
- All outputs except o_ready are registered. o_onehot = 1 << o_code in HOLD/SCAN and 8'h00 in IDLE.
- Acceptance latency: 1 cycle. o_onehot reflects the new code on the edge of the transfer.
- States:
  - IDLE: transfer -> HOLD; latch o_code=i_code; counter=HOLD_CYCLES-1. Else i_en && i_scan -> SCAN; o_code=0; divider=0. Else stay.
  - HOLD: o_ready=0, so i_valid is ignored and not queued. If counter==0 -> IDLE and o_onehot clears on that edge. Else counter decrements. One-hot is visible for exactly HOLD_CYCLES cycles.
  - SCAN: transfer has priority over stepping: load code and go HOLD. Else if !i_scan -> IDLE. Else when divider==SCAN_DIV-1, set divider=0 and o_code=o_code+1 mod 8 (7 wraps to 0). Otherwise divider increments.
- i_en=0 in any state -> IDLE on the next edge, outputs cleared; in-flight hold is abandoned.
- After HOLD, the block always returns to IDLE, even if i_scan is high. SCAN re-enters from IDLE on the following edge.
- Simultaneous i_valid and i_scan in IDLE: the transfer wins.
- Reset asserted mid-HOLD or mid-SCAN: outputs go to reset values immediately, asynchronously.
- Counter widths are $clog2 of the parameter, minimum 1 bit.

Optional Feature:
DECODE38_ACTIVE_LOW_EN
- Defined: o_onehot is driven inverted (one-cold: active bit 0, others 1), for common-anode LEDs. Reset and IDLE value is 8'hFF.
- Undefined: active-high as described above. State machine and timing are identical in both builds.

Test Plan:
- Reset, i_en=1, no stimulus -> o_onehot=8'h00, o_code=0, o_ready=1, o_active=0.
- HOLD_CYCLES=16, IDLE, i_valid=1, i_code=5 for 1 cycle -> o_onehot=8'h20 for exactly 16 cycles, o_ready=0 throughout, then 8'h00 and o_ready=1.
- During HOLD, pulse i_valid with i_code=2 -> ignored; o_onehot stays 8'h20.
- SCAN_DIV=4, i_scan=1 -> o_onehot 01,02,04,...,80,01, each held 4 cycles; wraps 7->0. Drop i_scan -> 00 next edge.
- In SCAN at code 3, i_valid=1 with i_code=6 -> HOLD with 8'h40. After hold, returns to IDLE 1 cycle, then re-enters SCAN at code 0.
- Deassert i_en mid-HOLD -> 8'h00 next edge. Assert i_rst_n=0 mid-SCAN -> outputs 0 immediately, without a clock edge. Active-low build -> 8'hFF.
